// File: rtl/step_pkg.sv
// Shared step-generation definitions: scheduler FSM encoding and default driver timing.
// The gearbox follower and the jog generator use the same tick constants.
package step_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_DIR_SETUP = 2'd1,
    ST_PULSE     = 2'd2,
    ST_GAP       = 2'd3
  } step_state_t;

  localparam int PULSE_TICKS_DEF      = 5;
  localparam int DIR_SETUP_TICKS_DEF  = 3;
  localparam int MIN_PERIOD_TICKS_DEF = 16;
  localparam int PEND_BITS_DEF        = 8;

endpackage

// File: rtl/step_timer.sv
// Loadable down counter that stops at zero; done is high while the count is zero.
// A load value of N makes done rise N edges after the load edge.
module step_timer #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign done = (cnt_q == '0);

endmodule

// File: rtl/step_scheduler.sv
// Arbitrates two step sources onto one stepper driver, buffering strobes in a signed
// pending counter and replaying them with guaranteed dir setup, pulse width and period.
module step_scheduler
  import step_pkg::*;
#(
  parameter int PULSE_TICKS      = PULSE_TICKS_DEF,
  parameter int DIR_SETUP_TICKS  = DIR_SETUP_TICKS_DEF,
  parameter int MIN_PERIOD_TICKS = MIN_PERIOD_TICKS_DEF,
  parameter int PEND_BITS        = PEND_BITS_DEF
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        enable,
  input  logic                        sel,
  input  logic                        a_step,
  input  logic                        a_dir,
  input  logic                        b_step,
  input  logic                        b_dir,
  input  logic                        clr_overflow,
  output logic                        step_pulse,
  output logic                        dir,
  output logic                        active_sel,
  output logic                        busy,
  output logic                        overflow,
  output logic signed [PEND_BITS-1:0] pending
);

  localparam int TICK_MAX = (MIN_PERIOD_TICKS > DIR_SETUP_TICKS) ?
                            MIN_PERIOD_TICKS : DIR_SETUP_TICKS;
  localparam int TW = $clog2(TICK_MAX + 1);
  localparam int SW = PEND_BITS + 2;

  localparam logic signed [PEND_BITS-1:0] PEND_MAX = {1'b0, {(PEND_BITS-1){1'b1}}};
  localparam logic signed [PEND_BITS-1:0] PEND_MIN = -PEND_MAX;
  localparam logic signed [SW-1:0]        SUM_MAX  = {2'b00, PEND_MAX};
  localparam logic signed [SW-1:0]        SUM_MIN  = -SUM_MAX;
  localparam logic signed [SW-1:0]        ONE      = {{(SW-1){1'b0}}, 1'b1};

  step_state_t state_q, state_d;
  logic signed [PEND_BITS-1:0] pending_q, pending_d;
  logic step_q, step_d, dir_q, dir_d, active_q, ovf_q, ovf_d;
  logic ph_load, ph_done, per_load, per_done, go_pulse;
  logic [TW-1:0] ph_val;
  logic src_step, src_dir, accept, pend_pos, pend_nz, can_go, sat;
  logic signed [SW-1:0] acc_delta, iss_delta, sum;

  function automatic logic sat_hit(input logic signed [SW-1:0] s);
    return (s > SUM_MAX) || (s < SUM_MIN);
  endfunction

  function automatic logic signed [PEND_BITS-1:0] sat_pend(input logic signed [SW-1:0] s);
    if (s > SUM_MAX)      return PEND_MAX;
    else if (s < SUM_MIN) return PEND_MIN;
    else                  return s[PEND_BITS-1:0];
  endfunction

  step_timer #(.W(TW)) u_phase_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (ph_load),
    .load_val (ph_val),
    .done     (ph_done)
  );

  step_timer #(.W(TW)) u_period_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (per_load),
    .load_val (TW'(MIN_PERIOD_TICKS - 1)),
    .done     (per_done)
  );

  assign pend_nz  = (pending_q != '0);
  assign pend_pos = pend_nz && !pending_q[PEND_BITS-1];
  assign can_go   = enable && pend_nz;

  // Sequencing: the next pulse may start straight out of GAP so rises stay exactly one period apart
  always_comb begin
    state_d  = state_q;
    step_d   = step_q;
    dir_d    = dir_q;
    ph_load  = 1'b0;
    ph_val   = '0;
    per_load = 1'b0;
    go_pulse = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (can_go) begin
          if (pend_pos == dir_q) begin
            go_pulse = 1'b1;
          end else begin
            dir_d   = pend_pos;
            state_d = ST_DIR_SETUP;
            ph_load = 1'b1;
            ph_val  = TW'(DIR_SETUP_TICKS - 1);
          end
        end
      end
      ST_DIR_SETUP: begin
        if (ph_done) begin
          if (can_go && pend_pos == dir_q) go_pulse = 1'b1;
          else                             state_d  = ST_IDLE;
        end
      end
      ST_PULSE: begin
        if (ph_done) begin
          step_d  = 1'b0;
          state_d = ST_GAP;
        end
      end
      ST_GAP: begin
        if (per_done) begin
          if (can_go && pend_pos == dir_q) go_pulse = 1'b1;
          else                             state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (go_pulse) begin
      state_d  = ST_PULSE;
      step_d   = 1'b1;
      ph_load  = 1'b1;
      ph_val   = TW'(PULSE_TICKS - 1);
      per_load = 1'b1;
    end
  end

  // Pending update: accepted strobe and issued step combine before saturation
  always_comb begin
    src_step  = active_q ? b_step : a_step;
    src_dir   = active_q ? b_dir  : a_dir;
    accept    = enable && src_step;
    acc_delta = accept ? (src_dir ? ONE : -ONE) : '0;
    iss_delta = go_pulse ? (pend_pos ? -ONE : ONE) : '0;
    sum       = {{2{pending_q[PEND_BITS-1]}}, pending_q} + acc_delta + iss_delta;
    sat       = sat_hit(sum);
    pending_d = enable ? sat_pend(sum) : '0;
    ovf_d     = sat ? 1'b1 : (clr_overflow ? 1'b0 : ovf_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      step_q    <= 1'b0;
      dir_q     <= 1'b0;
      active_q  <= 1'b0;
      ovf_q     <= 1'b0;
      pending_q <= '0;
    end else begin
      state_q   <= state_d;
      step_q    <= step_d;
      dir_q     <= dir_d;
      ovf_q     <= ovf_d;
      pending_q <= pending_d;
      // Source handover only when nothing is buffered or in flight
      if (state_q == ST_IDLE && !pend_nz) active_q <= sel;
    end
  end

  assign step_pulse = step_q;
  assign dir        = dir_q;
  assign active_sel = active_q;
  assign overflow   = ovf_q;
  assign pending    = pending_q;
  assign busy       = (state_q != ST_IDLE) || pend_nz;

endmodule

// File: tb/tb_step_scheduler.sv
// Randomized bench for step_scheduler against a timing-rule reference model
// (earliest legal rise / dir-change times derived from the last rise and last dir change).
module tb_step_scheduler;

  localparam int PT   = 5;
  localparam int DT   = 3;
  localparam int MP   = 16;
  localparam int PB   = 8;
  localparam int PMAX = 127;

  logic clk = 1'b0;
  logic rst, enable, sel, a_step, a_dir, b_step, b_dir, clr_overflow;
  logic step_pulse, dir, active_sel, busy, overflow;
  logic signed [PB-1:0] pending;

  always #5 clk = ~clk;

  step_scheduler #(
    .PULSE_TICKS      (PT),
    .DIR_SETUP_TICKS  (DT),
    .MIN_PERIOD_TICKS (MP),
    .PEND_BITS        (PB)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .sel          (sel),
    .a_step       (a_step),
    .a_dir        (a_dir),
    .b_step       (b_step),
    .b_dir        (b_dir),
    .clr_overflow (clr_overflow),
    .step_pulse   (step_pulse),
    .dir          (dir),
    .active_sel   (active_sel),
    .busy         (busy),
    .overflow     (overflow),
    .pending      (pending)
  );

  int checks = 0;
  int errors = 0;
  int n = 0;

  // Reference model state
  int m_pend, m_lr, m_dc;
  bit m_dir, m_sel, m_ovf;

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at edge %0d", tag, obs, exp, n);
    end
  endtask

  function automatic bit idle_before(input int e);
    return (e >= m_lr + MP + 1) && (e >= m_dc + DT + 1);
  endfunction

  task automatic model_reset();
    m_pend = 0; m_dir = 0; m_sel = 0; m_ovf = 0;
    m_lr = n - 1000; m_dc = n - 1000;
  endtask

  task automatic check_outputs();
    chk("step_pulse", step_pulse, (n >= m_lr && n - m_lr < PT) ? 1 : 0);
    chk("dir", dir, m_dir);
    chk("active_sel", active_sel, m_sel);
    chk("pending", pending, m_pend);
    chk("overflow", overflow, m_ovf);
    chk("busy", busy, (!idle_before(n + 1) || m_pend != 0) ? 1 : 0);
  endtask

  task automatic tick();
    bit s_step, s_dir, idle, rise, dchg, sat;
    int acc, sum, nxt;
    @(posedge clk);
    n++;
    idle   = idle_before(n);
    s_step = m_sel ? b_step : a_step;
    s_dir  = m_sel ? b_dir : a_dir;
    acc    = (enable && s_step) ? (s_dir ? 1 : -1) : 0;
    rise   = enable && m_pend != 0 && ((m_pend > 0) == m_dir) &&
             (n >= m_lr + MP) && (n >= m_dc + DT);
    dchg   = enable && m_pend != 0 && ((m_pend > 0) != m_dir) && idle;
    sum    = m_pend + acc + (rise ? ((m_pend > 0) ? -1 : 1) : 0);
    sat    = (sum > PMAX) || (sum < -PMAX);
    nxt    = !enable ? 0 : (sum > PMAX ? PMAX : (sum < -PMAX ? -PMAX : sum));
    m_ovf  = sat ? 1'b1 : (clr_overflow ? 1'b0 : m_ovf);
    if (idle && m_pend == 0) m_sel = sel;
    if (rise) m_lr = n;
    if (dchg) begin
      m_dir = (m_pend > 0);
      m_dc  = n;
    end
    m_pend = nxt;
    #1;
    check_outputs();
  endtask

  task automatic quiet(input int cycles);
    a_step = 0; b_step = 0; clr_overflow = 0;
    for (int i = 0; i < cycles; i++) tick();
  endtask

  task automatic drain(input int max_cycles);
    int i;
    a_step = 0; b_step = 0; clr_overflow = 0; enable = 1;
    i = 0;
    while (i < max_cycles && (m_pend != 0 || !idle_before(n + 1) || m_sel != sel)) begin
      tick();
      i++;
    end
    chk("drain_busy", busy, 0);
  endtask

  task automatic strobes_a(input int count, input bit d);
    a_dir = d;
    for (int i = 0; i < count; i++) begin
      a_step = 1;
      tick();
    end
    a_step = 0;
  endtask

  task automatic run_rand(input int cycles, input int p_step, input int p_dir,
                          input int p_sel, input int p_en);
    for (int i = 0; i < cycles; i++) begin
      a_step = ($urandom_range(99) < p_step);
      b_step = ($urandom_range(99) < p_step);
      if ($urandom_range(99) < p_dir) a_dir = ~a_dir;
      if ($urandom_range(99) < p_dir) b_dir = ~b_dir;
      if ($urandom_range(999) < p_sel) sel = ~sel;
      if ($urandom_range(999) < p_en) enable = ~enable;
      clr_overflow = ($urandom_range(99) < 2);
      tick();
    end
    a_step = 0; b_step = 0; clr_overflow = 0; enable = 1;
  endtask

  initial begin
    int w;
    rst = 1; enable = 0; sel = 0; a_step = 0; a_dir = 1;
    b_step = 0; b_dir = 1; clr_overflow = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outputs();
    rst = 0;
    enable = 1;

    // Single step from reset dir (includes a dir setup), then one with dir already matching
    strobes_a(1, 1'b1);
    quiet(30);
    strobes_a(1, 1'b1);
    quiet(25);

    // Burst of four forward strobes
    strobes_a(4, 1'b1);
    quiet(80);

    // Reversal: two forward then three reverse
    strobes_a(2, 1'b1);
    quiet(4);
    strobes_a(3, 1'b0);
    drain(200);

    // Randomized traffic: sparse, bursty, with enable toggling
    run_rand(1500, 5, 10, 8, 0);
    run_rand(800, 40, 3, 4, 0);
    run_rand(800, 20, 10, 10, 15);
    drain(3000);

    // Saturation, clear while still saturating, then clear alone and drain
    sel = 0;
    drain(100);
    strobes_a(160, 1'b1);
    chk("sat_overflow", overflow, 1);
    chk("sat_pending", pending, PMAX);
    a_step = 1; clr_overflow = 1;
    tick();
    a_step = 0;
    tick();
    clr_overflow = 0;
    chk("ovf_cleared", overflow, 0);
    drain(2500);

    // Source switch requested while steps are still pending
    strobes_a(2, 1'b1);
    sel = 1;
    for (int i = 0; i < 80; i++) begin
      a_step = ($urandom_range(99) < 10);
      b_step = ($urandom_range(99) < 10);
      b_dir  = $urandom_range(1);
      tick();
    end
    drain(2000);
    chk("switched_sel", active_sel, 1);

    // Async reset in the middle of a pulse
    sel = 0;
    drain(100);
    strobes_a(1, ~m_dir);
    w = 0;
    while (w < 40 && m_lr != n) begin
      tick();
      w++;
    end
    tick();
    chk("pulse_before_rst", step_pulse, 1);
    #2 rst = 1;
    #1;
    chk("rst_truncates", step_pulse, 0);
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    check_outputs();
    rst = 0;
    quiet(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
